cic_comp_fir: RTL and testbench

- Compensation FIR decimator placed directly downstream of the memcic CIC decimator.
- Consumes the CIC's sparse data_val_o/data_o stream.
- Flattens the CIC passband droop and decimates by DECIM.
- Time-multiplexed: one multiplier, one MAC cycle per tap, so a single instance serves slow CIC output rates cheaply.

---
 rtl/cic_comp_pkg.sv | 39 +++
 rtl/cic_comp_mac.sv | 47 ++++
 rtl/cic_comp_fir.sv | 112 +++++++++++
 tb/tb_cic_comp_fir.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/cic_comp_pkg.sv
// Shared types and helpers for the CIC compensation FIR decimator.
// Holds the FSM encoding, the default 16-tap droop-compensation kernel and width/saturation helpers.
package cic_comp_pkg;

   localparam int CC_TAPS   = 16;
   localparam int CC_COEF_W = 16;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_MAC,
      ST_ROUND,
      ST_OUT
   } state_t;

   typedef logic signed [CC_COEF_W-1:0] coef_arr_t [CC_TAPS];

   // Symmetric kernel with a raised centre to lift the CIC passband edge; taps sum to 16384.
   localparam coef_arr_t DEFAULT_COEF = '{
      -16'sd64,  -16'sd128, 16'sd0,    16'sd256,
       16'sd512,  16'sd0,  -16'sd1024, 16'sd8640,
       16'sd8640,-16'sd1024, 16'sd0,   16'sd512,
       16'sd256,  16'sd0,  -16'sd128, -16'sd64
   };

   function automatic int acc_width(input int wi, input int cw, input int taps);
      return wi + cw + $clog2(taps);
   endfunction

   function automatic longint sat_fn(input longint v, input int wo);
      longint hi;
      longint lo;
      hi = (longint'(1) <<< (wo - 1)) - 1;
      lo = -(longint'(1) <<< (wo - 1));
      if (v > hi)      return hi;
      else if (v < lo) return lo;
      else             return v;
   endfunction

endpackage

// File: rtl/cic_comp_mac.sv
// Single-multiplier accumulator with round-half-up and output saturation.
// Accumulates one product per enabled cycle; result register updates one cycle after finish.
module cic_comp_mac
   import cic_comp_pkg::*;
#(
   parameter int WIDTH_I   = 17,
   parameter int WIDTH_O   = 18,
   parameter int COEF_W    = 16,
   parameter int COEF_FRAC = 14,
   parameter int ACC_W     = 37
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      clear,
   input  logic                      en,
   input  logic                      finish,
   input  logic signed [WIDTH_I-1:0] sample,
   input  logic signed [COEF_W-1:0]  coef,
   output logic signed [WIDTH_O-1:0] sat
);

   localparam logic signed [ACC_W-1:0] RND = ACC_W'(1) << (COEF_FRAC - 1);

   logic signed [WIDTH_I+COEF_W-1:0] prod;
   logic signed [ACC_W-1:0]          acc;
   logic signed [ACC_W-1:0]          rnd;

   always_comb begin
      prod = (WIDTH_I+COEF_W)'(sample) * (WIDTH_I+COEF_W)'(coef);
      rnd  = (acc + RND) >>> COEF_FRAC;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc <= '0;
         sat <= '0;
      end else begin
         if (clear)
            acc <= '0;
         else if (en)
            acc <= acc + ACC_W'(prod);
         if (finish)
            sat <= WIDTH_O'(sat_fn(longint'(rnd), WIDTH_O));
      end
   end

endmodule

// File: rtl/cic_comp_fir.sv
// Time-multiplexed compensation FIR decimator behind the CIC; one MAC per tap per output.
// Output strobe TAPS+2 clocks after a trigger; input strobes while busy are dropped and flag error_o.
module cic_comp_fir
   import cic_comp_pkg::*;
#(
   parameter int        WIDTH_I   = 17,
   parameter int        WIDTH_O   = 18,
   parameter int        COEF_W    = 16,
   parameter int        COEF_FRAC = 14,
   parameter int        TAPS      = 16,
   parameter int        DECIM     = 2,
   parameter coef_arr_t COEF      = DEFAULT_COEF
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic signed [WIDTH_I-1:0] data_i,
   input  logic                      data_val_i,
   output logic signed [WIDTH_O-1:0] data_o,
   output logic                      data_val_o,
   output logic                      busy_o,
   output logic                      error_o
);

   localparam int PW    = $clog2(TAPS);
   localparam int PHW   = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int ACC_W = acc_width(WIDTH_I, COEF_W, TAPS);

   state_t                    state;
   logic signed [WIDTH_I-1:0] dl [TAPS];
   logic [PW-1:0]             wr_ptr;
   logic [PW-1:0]             k;
   logic [PHW-1:0]            phase;
   logic [PW-1:0]             rd_idx;
   logic                      trigger;
   logic signed [WIDTH_I-1:0] sample;
   logic signed [COEF_W-1:0]  coef;
   logic signed [WIDTH_O-1:0] sat;

   // wr_ptr already points past the newest sample while MAC runs, hence the extra -1.
   always_comb begin
      trigger = (state == ST_IDLE) && data_val_i && (phase == PHW'(DECIM - 1));
      rd_idx  = wr_ptr - PW'(1) - k;
      sample  = dl[rd_idx];
      coef    = COEF[k];
   end

   cic_comp_mac #(
      .WIDTH_I   (WIDTH_I),
      .WIDTH_O   (WIDTH_O),
      .COEF_W    (COEF_W),
      .COEF_FRAC (COEF_FRAC),
      .ACC_W     (ACC_W)
   ) u_mac (
      .clk    (clk_i),
      .rst    (rst_i),
      .clear  (trigger),
      .en     (state == ST_MAC),
      .finish (state == ST_ROUND),
      .sample (sample),
      .coef   (coef),
      .sat    (sat)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state      <= ST_IDLE;
         wr_ptr     <= '0;
         k          <= '0;
         phase      <= '0;
         data_o     <= '0;
         data_val_o <= 1'b0;
         busy_o     <= 1'b0;
         error_o    <= 1'b0;
         for (int i = 0; i < TAPS; i++)
            dl[i] <= '0;
      end else begin
         data_val_o <= 1'b0;
         if (data_val_i && state != ST_IDLE)
            error_o <= 1'b1;
         case (state)
            ST_IDLE: begin
               if (data_val_i) begin
                  dl[wr_ptr] <= data_i;
                  wr_ptr     <= wr_ptr + PW'(1);
                  if (trigger) begin
                     phase  <= '0;
                     k      <= '0;
                     state  <= ST_MAC;
                     busy_o <= 1'b1;
                  end else begin
                     phase <= phase + PHW'(1);
                  end
               end
            end
            ST_MAC: begin
               k <= k + PW'(1);
               if (k == PW'(TAPS - 1))
                  state <= ST_ROUND;
            end
            ST_ROUND: state <= ST_OUT;
            ST_OUT: begin
               data_o     <= sat;
               data_val_o <= 1'b1;
               busy_o     <= 1'b0;
               state      <= ST_IDLE;
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_cic_comp_fir.sv
// Scoreboard bench: two instances (18-bit and 16-bit outputs) share one stimulus stream.
module tb_cic_comp_fir;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic signed [16:0] data = '0;
   logic               val = 1'b0;

   logic signed [17:0] w_dat;
   logic               w_val, w_busy, w_err;
   logic signed [15:0] n_dat;
   logic               n_val, n_busy, n_err;

   cic_comp_fir #(.WIDTH_O(18)) u_w (
      .clk_i(clk), .rst_i(rst), .data_i(data), .data_val_i(val),
      .data_o(w_dat), .data_val_o(w_val), .busy_o(w_busy), .error_o(w_err)
   );

   cic_comp_fir #(.WIDTH_O(16)) u_n (
      .clk_i(clk), .rst_i(rst), .data_i(data), .data_val_i(val),
      .data_o(n_dat), .data_val_o(n_val), .busy_o(n_busy), .error_o(n_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      longint v;
      longint t;
   } exp_t;

   exp_t   qw[$];
   exp_t   qn[$];
   longint obs_w[$];
   longint hist[$];
   longint cyc = 0;
   longint busy_until = -1;
   int     ph = 0;
   int     strobes = 0;
   int     total = 0;
   int     bad = 0;

   int coef_m[16] = '{-64, -128, 0, 256, 512, 0, -1024, 8640,
                      8640, -1024, 0, 512, 256, 0, -128, -64};
   // Impulse of 16384 reproduces coef[1], coef[3], ... then zeros.
   int imp_exp[10] = '{-128, 256, 0, 8640, -1024, 512, 0, -64, 0, 0};

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string nm, input longint got, input longint want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, got, want);
      end
   endtask

   function automatic longint sat_m(input longint v, input int wo);
      longint hi = (longint'(1) <<< (wo - 1)) - 1;
      longint lo = -(longint'(1) <<< (wo - 1));
      return (v > hi) ? hi : ((v < lo) ? lo : v);
   endfunction

   // e is the clock edge that samples the strobe; the FSM is busy on edges T+1..T+18.
   task automatic model_accept(input longint x, input longint e);
      longint acc;
      longint r;
      exp_t   ex;
      if (e <= busy_until) return;
      hist.push_front(x);
      if (hist.size() > 16) void'(hist.pop_back());
      ph++;
      if (ph == 2) begin
         ph  = 0;
         acc = 0;
         for (int i = 0; i < hist.size(); i++)
            acc += longint'(coef_m[i]) * hist[i];
         r = (acc + 8192) >>> 14;
         busy_until = e + 18;
         ex.t = e + 18;
         ex.v = sat_m(r, 18);
         qw.push_back(ex);
         ex.v = sat_m(r, 16);
         qn.push_back(ex);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (!rst) begin
         if (w_val) begin
            strobes++;
            obs_w.push_back(longint'(w_dat));
            if (qw.size() == 0) check("w_unexpected_strobe", 1, 0);
            else begin
               e = qw.pop_front();
               check("w_value", longint'(w_dat), e.v);
               check("w_latency", cyc, e.t);
            end
         end
         if (n_val) begin
            if (qn.size() == 0) check("n_unexpected_strobe", 1, 0);
            else begin
               e = qn.pop_front();
               check("n_value", longint'(n_dat), e.v);
               check("n_latency", cyc, e.t);
            end
         end
      end
   end

   task automatic send(input longint x, input int gap);
      @(posedge clk); #1;
      data = 17'(x);
      val  = 1'b1;
      model_accept(x, cyc + 1);
      @(posedge clk); #1;
      val = 1'b0;
      repeat (gap - 2) @(posedge clk);
   endtask

   task automatic do_reset();
      @(posedge clk); #1;
      rst = 1'b1;
      val = 1'b0;
      qw.delete();
      qn.delete();
      hist.delete();
      ph = 0;
      busy_until = -1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((qw.size() != 0 || qn.size() != 0) && n < 300) begin
         @(posedge clk);
         n++;
      end
      #1 check("drain_pending", qw.size() + qn.size(), 0);
   endtask

   task automatic dc_run(input string nm);
      obs_w.delete();
      for (int i = 0; i < 40; i++) send(1000, 64);
      drain();
      check({nm, "_count"}, obs_w.size(), 20);
      for (int i = 7; i < obs_w.size(); i++) check({nm, "_settled"}, obs_w[i], 1000);
      check({nm, "_hold"}, longint'(w_dat), 1000);
   endtask

   initial begin
      int snap;

      do_reset();
      check("rst_data_o", longint'(w_dat), 0);
      check("rst_data_val_o", w_val, 0);
      check("rst_busy_o", w_busy, 0);
      check("rst_error_o", w_err, 0);
      check("rst_n_data_o", longint'(n_dat), 0);
      repeat (100) @(posedge clk);
      #1 check("quiet_after_reset", strobes, 0);

      dc_run("dc");

      do_reset();
      obs_w.delete();
      send(16384, 64);
      for (int i = 0; i < 19; i++) send(0, 64);
      drain();
      check("imp_count", obs_w.size(), 10);
      for (int i = 0; i < 10 && i < obs_w.size(); i++) check("imp_coef", obs_w[i], imp_exp[i]);

      do_reset();
      for (int i = 0; i < 20; i++) send(65535, 64);
      drain();
      check("sat_pos_n", longint'(n_dat), 32767);
      check("sat_pos_w", longint'(w_dat), 65535);
      for (int i = 0; i < 20; i++) send(-65536, 64);
      drain();
      check("sat_neg_n", longint'(n_dat), -32768);
      check("sat_neg_w", longint'(w_dat), -65536);

      do_reset();
      check("ovr_err_before", w_err, 0);
      send(500, 64);
      send(1000, 3);
      @(posedge clk); #1;
      data = 17'sd7000;
      val  = 1'b1;
      model_accept(7000, cyc + 1);
      @(posedge clk); #1;
      val = 1'b0;
      check("ovr_err_set", w_err, 1);
      check("ovr_busy_inflight", w_busy, 1);
      repeat (62) @(posedge clk);
      for (int i = 1; i <= 10; i++) send(200 * i, 64);
      drain();
      check("ovr_err_sticky", w_err, 1);
      check("ovr_n_err_sticky", n_err, 1);

      do_reset();
      check("rst_clears_err", w_err, 0);
      send(1000, 64);
      @(posedge clk); #1;
      data = 17'sd1000;
      val  = 1'b1;
      model_accept(1000, cyc + 1);
      @(posedge clk); #1;
      val = 1'b0;
      repeat (4) @(posedge clk);
      snap = strobes;
      do_reset();
      repeat (40) @(posedge clk);
      #1;
      check("abort_no_strobe", strobes - snap, 0);
      check("abort_busy", w_busy, 0);
      dc_run("dc_after_abort");

      check("final_pending", qw.size() + qn.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #3ms;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1);
   end

endmodule
